// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath.
// Holds the coin bus encoding, the rupee value of each denomination, the
// payout scheduler state type and a helper mapping a coin code to its value.
// Both the vending FSM and the payout scheduler import this package.
package vending_pkg;

   // Coin bus encoding, shared by the acceptor, hopper and refill paths
   localparam logic [1:0] COIN_1    = 2'b00;
   localparam logic [1:0] COIN_2    = 2'b01;
   localparam logic [1:0] COIN_5    = 2'b10;
   localparam logic [1:0] COIN_NONE = 2'b11;

   // Denomination values in rupees, sized to the 7-bit amount bus
   localparam logic [6:0] VAL_1 = 7'd1;
   localparam logic [6:0] VAL_2 = 7'd2;
   localparam logic [6:0] VAL_5 = 7'd5;

   typedef enum logic [1:0] {
      PAY_IDLE,
      PAY_SELECT,
      PAY_EJECT,
      PAY_FINISH
   } payout_state_t;

   // Rupee value of a coin code; COIN_NONE is worth nothing
   function automatic logic [6:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_1:  return VAL_1;
         COIN_2:  return VAL_2;
         COIN_5:  return VAL_5;
         default: return 7'd0;
      endcase
   endfunction

endpackage

// File: rtl/hopper_counter.sv
// Stock counter for a single coin hopper.
// Adds a refill quantity and subtracts one dropped coin in the same cycle,
// saturating at the counter maximum; a clear discards the current stock
// (used when the hopper jams) while still honouring a concurrent refill.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset (loads INIT)
//   add_qty_i     - coins added this cycle (0 when no refill targets this hopper)
//   dec_i         - one coin left the hopper this cycle
//   clr_i         - force the stock to zero
//   count_o       - current coin count
//   empty_o       - registered count==0 flag
module hopper_counter #(
   parameter int CNT_W = 8,
   parameter int INIT  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       add_qty_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   // Five extra bits cover a 4-bit refill on top of a full counter
   localparam int SUM_W = CNT_W + 5;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty_q;

   // Refill is applied before the decrement so a same-cycle refill and drop
   // nets to count + qty - 1, then the result clamps at the maximum
   always_comb begin
      sum = clr_i ? '0 : SUM_W'(cnt_q);
      sum = sum + SUM_W'(add_qty_i);
      if (dec_i && !clr_i && (sum != '0)) begin
         sum = sum - SUM_W'(1);
      end
      cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= CNT_W'(INIT);
         empty_q <= (INIT == 0);
      end else begin
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
      end
   end

   assign count_o = cnt_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/payout_scheduler.sv
// Coin change payout sequencer for the vending machine.
// Takes a refund amount from the vending FSM and drives the hopper one coin
// at a time, choosing ₹5, then ₹2, then ₹1 greedily from whatever stock is
// left. A hopper that never confirms a drop is declared jammed and its stock
// is written off. Reports the amount actually paid and whether it fell short.
// Ports:
//   clk, reset_n             - clock and asynchronous active-low reset
//   req_valid/req_amount     - payout request, accepted while req_ready is high
//   eject_valid/eject_coin   - hopper command, held until eject_done or timeout
//   eject_done               - hopper confirms one coin dropped
//   refill/refill_coin/qty   - stock added to one hopper, any state
//   done, paid, short        - completion pulse and result of the last request
//   hopper_empty             - {₹5, ₹2, ₹1} empty flags
//   jam                      - one-cycle pulse when an eject times out
module payout_scheduler
   import vending_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int INIT_5  = 10,
   parameter int INIT_2  = 10,
   parameter int INIT_1  = 10,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [6:0] req_amount,
   output logic       req_ready,
   output logic       eject_valid,
   output logic [1:0] eject_coin,
   input  logic       eject_done,
   input  logic       refill,
   input  logic [1:0] refill_coin,
   input  logic [3:0] refill_qty,
   output logic       done,
   output logic [6:0] paid,
   output logic       short,
   output logic [2:0] hopper_empty,
   output logic       jam
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // The wait counter starts at 0 on entry, so TIMEOUT eject cycles end here
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   payout_state_t    state_q, state_d;
   logic [6:0]       rem_q, rem_d, paid_q, paid_d;
   logic             short_q, short_d;
   logic [1:0]       coin_q, coin_d, sel_coin;
   logic [TW-1:0]    wait_q, wait_d;
   logic             jam_hit, jam_q;
   logic             req_ready_q, req_ready_d;
   logic             eject_valid_q, eject_valid_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] cnt_5, cnt_2, cnt_1;
   logic             empty_5, empty_2, empty_1;
   logic             dropped;
   logic [3:0]       add_5, add_2, add_1;

   // Confirmed drop and timeout only mean something while ejecting
   assign dropped = (state_q == PAY_EJECT) && eject_done;
   assign jam_hit = (state_q == PAY_EJECT) && !eject_done && (wait_q == WAIT_LAST);

   assign add_5 = (refill && (refill_coin == COIN_5)) ? refill_qty : 4'd0;
   assign add_2 = (refill && (refill_coin == COIN_2)) ? refill_qty : 4'd0;
   assign add_1 = (refill && (refill_coin == COIN_1)) ? refill_qty : 4'd0;

   hopper_counter #(.CNT_W(CNT_W), .INIT(INIT_5)) u_hopper_5 (
      .clk      (clk),
      .reset_n  (reset_n),
      .add_qty_i(add_5),
      .dec_i    (dropped && (coin_q == COIN_5)),
      .clr_i    (jam_hit && (coin_q == COIN_5)),
      .count_o  (cnt_5),
      .empty_o  (empty_5)
   );

   hopper_counter #(.CNT_W(CNT_W), .INIT(INIT_2)) u_hopper_2 (
      .clk      (clk),
      .reset_n  (reset_n),
      .add_qty_i(add_2),
      .dec_i    (dropped && (coin_q == COIN_2)),
      .clr_i    (jam_hit && (coin_q == COIN_2)),
      .count_o  (cnt_2),
      .empty_o  (empty_2)
   );

   hopper_counter #(.CNT_W(CNT_W), .INIT(INIT_1)) u_hopper_1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .add_qty_i(add_1),
      .dec_i    (dropped && (coin_q == COIN_1)),
      .clr_i    (jam_hit && (coin_q == COIN_1)),
      .count_o  (cnt_1),
      .empty_o  (empty_1)
   );

   // Greedy pick from registered stock, so a refill landing in this SELECT
   // cycle only counts from the next SELECT onwards
   always_comb begin
      sel_coin = COIN_NONE;
      if ((rem_q >= VAL_5) && (cnt_5 != '0)) begin
         sel_coin = COIN_5;
      end else if ((rem_q >= VAL_2) && (cnt_2 != '0)) begin
         sel_coin = COIN_2;
      end else if ((rem_q >= VAL_1) && (cnt_1 != '0)) begin
         sel_coin = COIN_1;
      end
   end

   // State register plus the payout datapath it carries
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PAY_IDLE;
         rem_q   <= '0;
         paid_q  <= '0;
         short_q <= 1'b0;
         coin_q  <= COIN_NONE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         paid_q  <= paid_d;
         short_q <= short_d;
         coin_q  <= coin_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic; a jam returns to SELECT with the stuck hopper emptied
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      paid_d  = paid_q;
      short_d = short_q;
      coin_d  = coin_q;
      wait_d  = wait_q;
      case (state_q)
         PAY_IDLE: begin
            if (req_valid) begin
               rem_d   = req_amount;
               paid_d  = '0;
               short_d = 1'b0;
               state_d = PAY_SELECT;
            end
         end
         PAY_SELECT: begin
            if (sel_coin != COIN_NONE) begin
               coin_d  = sel_coin;
               wait_d  = '0;
               state_d = PAY_EJECT;
            end else begin
               short_d = (rem_q != '0);
               state_d = PAY_FINISH;
            end
         end
         PAY_EJECT: begin
            if (eject_done) begin
               rem_d   = rem_q - coin_value(coin_q);
               paid_d  = paid_q + coin_value(coin_q);
               state_d = PAY_SELECT;
            end else if (jam_hit) begin
               state_d = PAY_SELECT;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         PAY_FINISH: begin
            state_d = PAY_IDLE;
         end
         default: begin
            state_d = PAY_IDLE;
         end
      endcase
   end

   // Handshake outputs follow the state being entered so they are registered
   always_comb begin
      req_ready_d   = (state_d == PAY_IDLE);
      eject_valid_d = (state_d == PAY_EJECT);
      done_d        = (state_d == PAY_FINISH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_ready_q   <= 1'b1;
         eject_valid_q <= 1'b0;
         done_q        <= 1'b0;
         jam_q         <= 1'b0;
      end else begin
         req_ready_q   <= req_ready_d;
         eject_valid_q <= eject_valid_d;
         done_q        <= done_d;
         jam_q         <= jam_hit;
      end
   end

   assign req_ready    = req_ready_q;
   assign eject_valid  = eject_valid_q;
   assign eject_coin   = coin_q;
   assign done         = done_q;
   assign paid         = paid_q;
   assign short        = short_q;
   assign jam          = jam_q;
   assign hopper_empty = {empty_5, empty_2, empty_1};

endmodule

// File: tb/tb_payout_scheduler.sv
// Self-checking bench for payout_scheduler.
// The reference model keeps hopper stock as plain integers and pays each
// request by the greedy rule; the bench plays the hopper, answering each
// eject after a delay or letting it time out, and checks every eject, the
// handshake timing and the final result against the model.
module tb_payout_scheduler;

   localparam int TIMEOUT  = 15;
   localparam int INIT_CNT = 10;
   localparam int CNT_MAX  = 255;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [6:0] req_amount = '0;
   logic       req_ready;
   logic       eject_valid;
   logic [1:0] eject_coin;
   logic       eject_done = 1'b0;
   logic       refill = 1'b0;
   logic [1:0] refill_coin = '0;
   logic [3:0] refill_qty = '0;
   logic       done;
   logic [6:0] paid;
   logic       short;
   logic [2:0] hopper_empty;
   logic       jam;

   int checks = 0;
   int errors = 0;

   // Model stock indexed by coin code: 0 = ₹1, 1 = ₹2, 2 = ₹5
   int cntM[3];
   int coinVal[3] = '{1, 2, 5};

   payout_scheduler #(
      .CNT_W  (8),
      .INIT_5 (INIT_CNT),
      .INIT_2 (INIT_CNT),
      .INIT_1 (INIT_CNT),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_amount  (req_amount),
      .req_ready   (req_ready),
      .eject_valid (eject_valid),
      .eject_coin  (eject_coin),
      .eject_done  (eject_done),
      .refill      (refill),
      .refill_coin (refill_coin),
      .refill_qty  (refill_qty),
      .done        (done),
      .paid        (paid),
      .short       (short),
      .hopper_empty(hopper_empty),
      .jam         (jam)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
      end
   endtask

   // Largest denomination not above the remainder with stock left, 3 = none
   function automatic int greedyCoin(input int rem);
      for (int k = 2; k >= 0; k--) begin
         if ((rem >= coinVal[k]) && (cntM[k] > 0)) return k;
      end
      return 3;
   endfunction

   function automatic void addStock(input int k, input int qty, input int dec);
      cntM[k] = cntM[k] + qty - dec;
      if (cntM[k] > CNT_MAX) cntM[k] = CNT_MAX;
   endfunction

   task automatic doRefill(input int coin, input int qty);
      @(negedge clk);
      refill      = 1'b1;
      refill_coin = 2'(coin);
      refill_qty  = 4'(qty);
      @(negedge clk);
      refill = 1'b0;
      if (coin < 3) addStock(coin, qty, 0);
   endtask

   // One full request. The first jamFirstN ejects are left to time out, later
   // ones jam with probability jamPct; rfCoin/rfQty < 0 pick random values for
   // refills issued alongside eject_done; strayPct drives eject_done in SELECT.
   task automatic applyStimulus(input int amount, input int jamFirstN, input int jamPct,
                                input int doneDelay, input int rfPct, input int rfCoin,
                                input int rfQty, input int strayPct);
      int  rem, paidM, k, n, ejects, rc, rq;
      bit  jamIt, finished;
      rem = amount;
      paidM = 0;
      ejects = 0;
      finished = 1'b0;
      @(negedge clk);
      checkOutput("ready_idle", req_ready, 1);
      req_valid  = 1'b1;
      req_amount = 7'(amount);
      @(negedge clk);
      req_valid = 1'b0;
      for (int it = 0; (it < 200) && !finished; it++) begin
         checkOutput("select_gap", {29'd0, eject_valid, done, req_ready}, 0);
         eject_done = ($urandom_range(99) < strayPct);
         @(negedge clk);
         eject_done = 1'b0;
         k = greedyCoin(rem);
         if (k == 3) begin
            checkOutput("done_pulse", {eject_valid, done}, 2'b01);
            checkOutput("paid", paid, paidM);
            checkOutput("short", short, (rem != 0));
            checkOutput("empty_flags", hopper_empty,
                        {cntM[2] == 0, cntM[1] == 0, cntM[0] == 0});
            @(negedge clk);
            checkOutput("done_width", {done, req_ready}, 2'b01);
            checkOutput("paid_hold", paid, paidM);
            finished = 1'b1;
         end else begin
            checkOutput("eject_start", {eject_valid, done}, 2'b10);
            checkOutput("eject_coin", eject_coin, k);
            if (eject_valid !== 1'b1) begin
               finished = 1'b1;
            end else begin
               jamIt = (ejects < jamFirstN) || ($urandom_range(99) < jamPct);
               ejects++;
               if (jamIt) begin
                  n = 1;
                  while (n <= TIMEOUT + 1) begin
                     @(negedge clk);
                     if (eject_valid !== 1'b1) break;
                     n++;
                  end
                  checkOutput("jam_len", n, TIMEOUT);
                  checkOutput("jam_pulse", jam, 1);
                  cntM[k] = 0;
               end else begin
                  repeat (doneDelay - 1) @(negedge clk);
                  checkOutput("eject_hold", {eject_valid, eject_coin}, {1'b1, 2'(k)});
                  eject_done = 1'b1;
                  rc = -1;
                  rq = 0;
                  if ($urandom_range(99) < rfPct) begin
                     rc = (rfCoin < 0) ? int'($urandom_range(3)) : rfCoin;
                     rq = (rfQty < 0) ? int'($urandom_range(15)) : rfQty;
                     refill      = 1'b1;
                     refill_coin = 2'(rc);
                     refill_qty  = 4'(rq);
                  end
                  @(negedge clk);
                  eject_done = 1'b0;
                  refill     = 1'b0;
                  if (rc == k) begin
                     addStock(k, rq, 1);
                  end else begin
                     addStock(k, 0, 1);
                     if ((rc >= 0) && (rc < 3)) addStock(rc, rq, 0);
                  end
                  rem   -= coinVal[k];
                  paidM += coinVal[k];
                  checkOutput("jam_quiet", jam, 0);
               end
            end
         end
      end
      if (!finished) checkOutput("req_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, wanted end of test");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      bit doneSeen;
      for (int k = 0; k < 3; k++) cntM[k] = INIT_CNT;

      // Reset state
      @(negedge clk);
      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_valid", eject_valid, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_jam", jam, 0);
      checkOutput("rst_short", short, 0);
      checkOutput("rst_paid", paid, 0);
      checkOutput("rst_empty", hopper_empty, 0);
      reset_n = 1'b1;

      // Full stock: ₹8 pays 5, 2, 1
      applyStimulus(8, 0, 0, 2, 0, 0, 0, 0);

      // Zero request finishes straight away
      applyStimulus(0, 0, 0, 2, 0, 0, 0, 0);

      // Empty every hopper through jams, then stock two ₹1 and ask for ₹4
      applyStimulus(5, 0, 100, 2, 0, 0, 0, 0);
      doRefill(0, 2);
      applyStimulus(4, 0, 0, 2, 0, 0, 0, 0);

      // Greedy shortfall: 5:1, 2:3, 1:0 asked for ₹6
      doRefill(2, 1);
      doRefill(1, 3);
      applyStimulus(6, 0, 0, 2, 0, 0, 0, 0);

      // Jam on the ₹5, then five ₹1 complete the payout
      applyStimulus(5, 0, 100, 2, 0, 0, 0, 0);
      doRefill(2, 1);
      doRefill(0, 5);
      applyStimulus(5, 1, 0, 2, 0, 0, 0, 0);

      // Refill ₹1 x4 alongside a ₹1 drop nets +3, seen by the next payout
      doRefill(0, 2);
      applyStimulus(1, 0, 0, 2, 100, 0, 4, 0);
      applyStimulus(7, 0, 0, 1, 0, 0, 0, 0);

      // Asynchronous reset in the middle of an eject
      doRefill(0, 3);
      @(negedge clk);
      req_valid  = 1'b1;
      req_amount = 7'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_eject", {eject_valid, eject_coin}, 3'b100);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("reset_drop_valid", eject_valid, 0);
      checkOutput("reset_ready", req_ready, 1);
      for (int k = 0; k < 3; k++) cntM[k] = INIT_CNT;
      @(negedge clk);
      reset_n = 1'b1;
      doneSeen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done !== 1'b0) doneSeen = 1'b1;
      end
      checkOutput("no_done_after_reset", doneSeen, 0);
      checkOutput("reset_empty_flags", hopper_empty, 0);
      checkOutput("reset_paid", paid, 0);
      applyStimulus(8, 0, 0, 2, 0, 0, 0, 0);

      // Randomised traffic with refills, jams, stray confirms and varying latency
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(99) < 30) begin
            doRefill(int'($urandom_range(3)), int'($urandom_range(15)));
         end
         applyStimulus(int'($urandom_range(30)), 0, 10, int'($urandom_range(1, 3)),
                       25, -1, -1, 20);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
